// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle memory freeze with timeout, and event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LEN_REG     = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEN_REG-1:0] id_rs,
  input  logic [LEN_REG-1:0] id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_mem_read,
  input  logic [LEN_REG-1:0] ex_rt,
  input  logic               mem_pc_src,
  input  logic               mem_access,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_flush,
  output logic               pipe_hold,
  output logic               mem_timeout,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD_MEM = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic                timeout_d;
  logic                load_use, mem_wait;
  logic                run_decode;
  logic                branch_taken;

  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mem_wait = mem_access && !mem_ready;
  assign state    = state_q;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    state_d      = state_q;
    wait_d       = wait_cnt;
    timeout_d    = mem_timeout;
    run_decode   = 1'b0;
    branch_taken = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_wait) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            wait_d      = WAIT_W'(1);
            state_d     = HOLD_MEM;
          end else begin
            run_decode = 1'b1;
          end
        end
        HOLD_MEM: begin
          if (!mem_ready) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
              timeout_d = 1'b1;
              state_d   = ERROR;
            end else begin
              wait_d = wait_cnt + WAIT_W'(1);
            end
          end else begin
            // Release cycle: branch/load-use held stable by the freeze act now.
            run_decode = 1'b1;
            wait_d     = '0;
            state_d    = RUN;
          end
        end
        ERROR: begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        default: state_d = RUN;
      endcase

      if (run_decode) begin
        if (mem_pc_src) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          branch_taken = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt    <= wait_d;
      mem_timeout <= timeout_d;
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
